// File: rtl/exp_pkg.sv
// exp_pkg: shared constants and width helpers for the streaming exp(x) engine.
//   - FP32 field positions and the exponent bias
//   - out_width / rem_bits / lut_depth width helpers
//   - lut_entry: elaboration-time value of one exp LUT knot
package exp_pkg;

    localparam int FP_SIGN    = 31;
    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;
    localparam int FP_MAN_MSB = 22;
    localparam int FP_MAN_W   = 23;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;

    // Q1.out_frac: one integer bit so that 1.0 is representable exactly.
    function automatic int out_width(input int out_frac);
        return out_frac + 1;
    endfunction

    // Number of |x| bits below the LUT index, used as the interpolation fraction.
    function automatic int rem_bits(input int int_bits, input int frac_bits, input int addr_bits);
        return int_bits + frac_bits - addr_bits;
    endfunction

    // One extra entry so that index i+1 exists for the top segment.
    function automatic int lut_depth(input int addr_bits);
        return (1 << addr_bits) + 1;
    endfunction

    // L[k] = round(exp(-k*step) * 2^out_frac), step = 2^int_bits / 2^addr_bits.
    function automatic int lut_entry(input int k, input int int_bits, input int addr_bits,
                                     input int out_frac);
        real step;
        real v;
        step = real'(1 << int_bits) / real'(1 << addr_bits);
        v    = $exp(-(real'(k) * step)) * real'(1 << out_frac);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/exp_lut_rom.sv
// exp_lut_rom: exp(-x) knot table with two registered read ports (i and i+1).
//   clk      in   clock
//   en       in   read enable; low holds both outputs (pipeline stall)
//   addr     in   ADDR_BITS segment index i
//   data_lo  out  L[i]
//   data_hi  out  L[i+1]
module exp_lut_rom
    import exp_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int INT_BITS  = 4,
    parameter int OUT_FRAC  = 15,
    localparam int OW       = out_width(OUT_FRAC)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [OW-1:0]        data_lo,
    output logic [OW-1:0]        data_hi
);

    localparam int DEPTH = lut_depth(ADDR_BITS);

    logic [OW-1:0]        rom [DEPTH];
    logic [ADDR_BITS:0]   addr_lo;
    logic [ADDR_BITS:0]   addr_hi;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom[gi] = OW'(lut_entry(gi, INT_BITS, ADDR_BITS, OUT_FRAC));
        end
    endgenerate

    assign addr_lo = {1'b0, addr};
    assign addr_hi = addr_lo + 1'b1;

    // No reset on the read registers so the table can map onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            data_lo <= rom[addr_lo];
            data_hi <= rom[addr_hi];
        end
    end

endmodule

// File: rtl/exp_stream_engine.sv
// exp_stream_engine: 3-stage streaming exp(x) for x <= 0 (FP32 in, Q1.OUT_FRAC out).
//   S1 FP32 -> |x| fixed point, S2 LUT read, S3 linear interpolation.
//   clock_i / reset_i (async, active high) / clear_i (sync flush)
//   exp_data_i, exp_data_valid_i, exp_data_ready_o   input stream
//   exp_data_o, exp_data_valid_o, exp_data_ready_i   output stream
//   exp_last_o   last sample of a NUMBER_OF_DATA vector
//   exp_done_o   pulse the cycle after the last sample is accepted
//   exp_range_err_o  sticky: positive or NaN input seen
module exp_stream_engine
    import exp_pkg::*;
#(
    parameter int NUMBER_OF_DATA = 10,
    parameter int INT_BITS       = 4,
    parameter int FRAC_BITS      = 16,
    parameter int ADDR_BITS      = 8,
    parameter int OUT_FRAC       = 15,
    localparam int OUT_WIDTH     = out_width(OUT_FRAC)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic [31:0]          exp_data_i,
    input  logic                 exp_data_valid_i,
    output logic                 exp_data_ready_o,
    output logic [OUT_WIDTH-1:0] exp_data_o,
    output logic                 exp_data_valid_o,
    input  logic                 exp_data_ready_i,
    output logic                 exp_last_o,
    output logic                 exp_done_o,
    output logic                 exp_range_err_o
);

    localparam int MAG_W  = INT_BITS + FRAC_BITS;
    localparam int RB     = rem_bits(INT_BITS, FRAC_BITS, ADDR_BITS);
    localparam int SH_OFS = FP_BIAS + FP_MAN_W - FRAC_BITS;
    localparam int WIDE_W = MAG_W + FP_MAN_W + 1;
    localparam int PROD_W = OUT_WIDTH + RB;
    localparam logic [7:0] LAST_IDX = 8'(NUMBER_OF_DATA - 1);
    localparam logic [7:0] EXP_ONES = 8'(FP_EXP_MAX);

    logic                 stall;
    logic                 accept;
    logic                 out_fire;

    logic                 sgn;
    logic [7:0]           expo;
    logic [FP_MAN_W-1:0]  man;
    logic [WIDE_W-1:0]    wide;
    int                   sh;
    logic [MAG_W-1:0]     mag_next;
    logic                 zero_next;
    logic                 err_next;

    logic                 s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [MAG_W-1:0]     s1_mag_reg;
    logic                 s1_zero_reg, s2_zero_reg;
    logic [RB-1:0]        s2_r_reg;
    logic [OUT_WIDTH-1:0] s3_data_reg;
    logic [7:0]           cnt_reg;
    logic                 done_reg;
    logic                 err_reg;

    logic [OUT_WIDTH-1:0] lut_lo, lut_hi;
    logic [OUT_WIDTH-1:0] diff;
    logic [PROD_W-1:0]    prod;
    logic [OUT_WIDTH-1:0] interp;

    assign stall            = s3_valid_reg & ~exp_data_ready_i;
    assign exp_data_ready_o = ~stall;
    assign accept           = exp_data_valid_i & exp_data_ready_o;
    assign out_fire         = s3_valid_reg & exp_data_ready_i;

    assign sgn  = exp_data_i[FP_SIGN];
    assign expo = exp_data_i[FP_EXP_MSB:FP_EXP_LSB];
    assign man  = exp_data_i[FP_MAN_MSB:0];

    // S1: FP32 -> |x| in Q(INT_BITS).FRAC_BITS; zero_next marks results forced to 0.
    always_comb begin
        mag_next  = '0;
        zero_next = 1'b0;
        err_next  = 1'b0;
        wide      = {{MAG_W{1'b0}}, 1'b1, man};
        sh        = int'(expo) - SH_OFS;
        if (expo == EXP_ONES && man != '0) begin
            zero_next = 1'b1;
            err_next  = 1'b1;
        end else if (!sgn && (expo != '0 || man != '0)) begin
            // positive input (including +inf and +denormal) evaluates as x = 0
            err_next = 1'b1;
        end else if (expo == '0) begin
            mag_next = '0;
        end else if (expo == EXP_ONES) begin
            zero_next = 1'b1;
        end else if (int'(expo) >= FP_BIAS + INT_BITS) begin
            zero_next = 1'b1;
        end else if (sh >= 0) begin
            mag_next = MAG_W'(wide << sh);
        end else begin
            mag_next = MAG_W'(wide >> (-sh));
        end
    end

    exp_lut_rom #(
        .ADDR_BITS (ADDR_BITS),
        .INT_BITS  (INT_BITS),
        .OUT_FRAC  (OUT_FRAC)
    ) u_rom (
        .clk     (clock_i),
        .en      (~stall),
        .addr    (s1_mag_reg[MAG_W-1 -: ADDR_BITS]),
        .data_lo (lut_lo),
        .data_hi (lut_hi)
    );

    // S3: the table is monotonically decreasing, so diff and the result never underflow.
    always_comb begin
        diff   = lut_lo - lut_hi;
        prod   = PROD_W'(diff) * PROD_W'(s2_r_reg);
        interp = s2_zero_reg ? '0 : (lut_lo - OUT_WIDTH'(prod >> RB));
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_reg <= 1'b0;
            s1_mag_reg   <= '0;
            s1_zero_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_r_reg     <= '0;
            s2_zero_reg  <= 1'b0;
            s3_valid_reg <= 1'b0;
            s3_data_reg  <= '0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else if (clear_i) begin
            s1_valid_reg <= 1'b0;
            s1_mag_reg   <= '0;
            s1_zero_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_r_reg     <= '0;
            s2_zero_reg  <= 1'b0;
            s3_valid_reg <= 1'b0;
            s3_data_reg  <= '0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (!stall) begin
                s1_valid_reg <= accept;
                s1_mag_reg   <= mag_next;
                s1_zero_reg  <= zero_next;
                s2_valid_reg <= s1_valid_reg;
                s2_r_reg     <= s1_mag_reg[RB-1:0];
                s2_zero_reg  <= s1_zero_reg;
                s3_valid_reg <= s2_valid_reg;
                s3_data_reg  <= s2_valid_reg ? interp : '0;
            end
            if (accept && err_next) begin
                err_reg <= 1'b1;
            end
            done_reg <= out_fire && (cnt_reg == LAST_IDX);
            if (out_fire) begin
                cnt_reg <= (cnt_reg == LAST_IDX) ? '0 : cnt_reg + 8'd1;
            end
        end
    end

    assign exp_data_o       = s3_data_reg;
    assign exp_data_valid_o = s3_valid_reg;
    assign exp_last_o       = s3_valid_reg & (cnt_reg == LAST_IDX);
    assign exp_done_o       = done_reg;
    assign exp_range_err_o  = err_reg;

endmodule

// File: tb/tb_exp_stream_engine.sv
module tb_exp_stream_engine;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        clear_i;
    logic [31:0] exp_data_i;
    logic        exp_data_valid_i;
    logic        exp_data_ready_o;
    logic [15:0] exp_data_o;
    logic        exp_data_valid_o;
    logic        exp_data_ready_i;
    logic        exp_last_o;
    logic        exp_done_o;
    logic        exp_range_err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] in_q[$];
    real         ideal_q[$];

    exp_stream_engine dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .clear_i          (clear_i),
        .exp_data_i       (exp_data_i),
        .exp_data_valid_i (exp_data_valid_i),
        .exp_data_ready_o (exp_data_ready_o),
        .exp_data_o       (exp_data_o),
        .exp_data_valid_o (exp_data_valid_o),
        .exp_data_ready_i (exp_data_ready_i),
        .exp_last_o       (exp_last_o),
        .exp_done_o       (exp_done_o),
        .exp_range_err_o  (exp_range_err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input real ideal, input real tol);
        bit ok;
        ok = ((real'(obs) - ideal) <= tol) && ((ideal - real'(obs)) <= tol);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%f tol=%f", tag, obs, ideal, tol);
        end
    endtask

    // Knot value round(exp(-k/16) * 2^15) for the default table step of 1/16.
    function automatic int knot(input int k);
        return $rtoi($exp(-real'(k) / 16.0) * 32768.0 + 0.5);
    endfunction

    // Real-valued linear interpolation between exact exp knots; linear
    // interpolation itself departs from exp by up to ~16 LSB near 0, so the
    // 2 LSB bound is applied against this curve.
    function automatic real interp_model(input int m);
        int  i;
        int  r;
        real a;
        real b;
        i = m >> 12;
        r = m & 4095;
        a = $exp(-real'(i) / 16.0) * 32768.0;
        b = $exp(-real'(i + 1) / 16.0) * 32768.0;
        return a - (a - b) * real'(r) / 4096.0;
    endfunction

    // Double -> single for values that are exactly representable in FP32.
    function automatic logic [31:0] to_fp32(input real v);
        logic [63:0] b;
        int          e;
        logic [7:0]  e8;
        if (v == 0.0) return 32'h0;
        b  = $realtobits(v);
        e  = int'(b[62:52]) - 1023 + 127;
        e8 = e[7:0];
        return {b[63], e8, b[51:29]};
    endfunction

    // One sample with ready_i=1: driven after edge t, expected valid after edge t+3.
    task automatic single(input string tag, input logic [31:0] x, input logic [15:0] expv,
                          input logic exp_err);
        int k;
        @(negedge clock_i);
        exp_data_ready_i = 1'b1;
        exp_data_valid_i = 1'b1;
        exp_data_i       = x;
        @(negedge clock_i);
        exp_data_valid_i = 1'b0;
        k = 1;
        while (!exp_data_valid_o && k < 10) begin
            @(negedge clock_i);
            k++;
        end
        $display("single %s x=0x%08h out=0x%04h lat=%0d err=%0b", tag, x, exp_data_o, k,
                 exp_range_err_o);
        check({tag, " latency"}, k, 3);
        check({tag, " data"}, exp_data_o, expv);
        check({tag, " err"}, exp_range_err_o, exp_err);
    endtask

    // Streams in_q, holds ready_i low for hold_len cycles starting at cycle hold_start,
    // and checks data, order, stability under stall, last/done and throughput.
    task automatic run_stream(input string tag, input int hold_start, input int hold_len,
                              input real tol);
        int          n, sent, got, cyc, first_cyc, last_cyc, dones, extra;
        bit          prev_stall, prev_last_acc;
        logic [15:0] prev_data;
        logic        prev_last_o;
        n = in_q.size();
        sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1; dones = 0; extra = 0;
        prev_stall = 1'b0; prev_last_acc = 1'b0; prev_data = '0; prev_last_o = 1'b0;
        while ((got < n || extra < 2) && cyc < 600) begin
            @(negedge clock_i);
            exp_data_ready_i = !(cyc >= hold_start && cyc < hold_start + hold_len);
            #1;
            if (exp_done_o) begin
                dones++;
                check({tag, " done_after_last"}, prev_last_acc, 1);
            end
            if (prev_stall) begin
                check({tag, " stall_valid"}, exp_data_valid_o, 1);
                check({tag, " stall_data"}, exp_data_o, prev_data);
                check({tag, " stall_last"}, exp_last_o, prev_last_o);
            end
            if (exp_data_valid_o && !exp_data_ready_i)
                check({tag, " stall_ready"}, exp_data_ready_o, 0);
            prev_last_acc = 1'b0;
            if (exp_data_valid_o && exp_data_ready_i) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (got < n) begin
                    $display("stream %s idx=%0d x=0x%08h out=0x%04h last=%0b", tag, got,
                             in_q[got], exp_data_o, exp_last_o);
                    if (tol == 0.0)
                        check({tag, " data"}, exp_data_o, $rtoi(ideal_q[got]));
                    else
                        check_near({tag, " data"}, int'(exp_data_o), ideal_q[got], tol);
                    check({tag, " last"}, exp_last_o, ((got % 10) == 9));
                end
                prev_last_acc = exp_last_o;
                got++;
            end
            prev_stall  = exp_data_valid_o && !exp_data_ready_i;
            prev_data   = exp_data_o;
            prev_last_o = exp_last_o;
            if (sent < n) begin
                exp_data_valid_i = 1'b1;
                exp_data_i       = in_q[sent];
                if (exp_data_ready_o) sent++;
            end else begin
                exp_data_valid_i = 1'b0;
            end
            if (got >= n) extra++;
            cyc++;
        end
        exp_data_valid_i = 1'b0;
        check({tag, " count"}, got, n);
        check({tag, " dones"}, dones, n / 10);
        if (hold_len == 0 && n > 0)
            check({tag, " throughput"}, last_cyc - first_cyc, n - 1);
        in_q.delete();
        ideal_q.delete();
    endtask

    task automatic pulse_clear();
        @(negedge clock_i);
        clear_i = 1'b1;
        @(negedge clock_i);
        clear_i = 1'b0;
    endtask

    initial begin
        int idx;
        int m;
        reset_i          = 1'b1;
        clear_i          = 1'b0;
        exp_data_i       = '0;
        exp_data_valid_i = 1'b0;
        exp_data_ready_i = 1'b1;

        // reset state
        #12;
        check("rst valid", exp_data_valid_o, 0);
        check("rst data", exp_data_o, 0);
        check("rst last", exp_last_o, 0);
        check("rst done", exp_done_o, 0);
        check("rst err", exp_range_err_o, 0);
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;

        // directed single samples
        single("zero", 32'h0000_0000, 16'h8000, 1'b0);
        single("m1", 32'hBF80_0000, 16'h2F17, 1'b0);
        single("m20", 32'hC1A0_0000, 16'h0000, 1'b0);
        single("ninf", 32'hFF80_0000, 16'h0000, 1'b0);
        single("p2", 32'h4000_0000, 16'h8000, 1'b1);
        single("sticky", 32'hBF80_0000, 16'h2F17, 1'b1);
        pulse_clear();
        #1;
        check("clear err", exp_range_err_o, 0);
        check("clear valid", exp_data_valid_o, 0);
        single("nan", 32'h7FC0_0000, 16'h0000, 1'b1);
        pulse_clear();

        // backpressure: 10 samples at x = -0.75*k, ready low for 5 cycles mid-stream
        for (int k = 0; k < 10; k++) begin
            in_q.push_back(to_fp32(-0.75 * real'(k)));
            ideal_q.push_back(real'(knot(12 * k)));
        end
        run_stream("bp", 5, 5, 0.0);

        // two back-to-back vectors
        for (int k = 0; k < 20; k++) begin
            idx = (k * 13) % 256;
            in_q.push_back(to_fp32(-real'(idx) / 16.0));
            ideal_q.push_back(real'(knot(idx)));
        end
        run_stream("vec", 0, 0, 0.0);

        // leave the counter part-way through a vector
        for (int k = 0; k < 4; k++) begin
            in_q.push_back(to_fp32(-real'(k) / 4.0));
            ideal_q.push_back(real'(knot(4 * k)));
        end
        run_stream("pre", 0, 0, 0.0);

        // reset with one sample held at the output and two more in flight
        @(negedge clock_i);
        exp_data_ready_i = 1'b0;
        exp_data_valid_i = 1'b1;
        exp_data_i       = 32'h4000_0000;
        @(negedge clock_i);
        exp_data_i       = 32'hBF80_0000;
        @(negedge clock_i);
        exp_data_i       = 32'hBF00_0000;
        @(negedge clock_i);
        exp_data_valid_i = 1'b0;
        @(negedge clock_i);
        check("inflight valid", exp_data_valid_o, 1);
        check("inflight err", exp_range_err_o, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst valid", exp_data_valid_o, 0);
        check("arst data", exp_data_o, 0);
        check("arst last", exp_last_o, 0);
        check("arst done", exp_done_o, 0);
        check("arst err", exp_range_err_o, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
        exp_data_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_q.push_back(to_fp32(-real'(k + 1) / 2.0));
            ideal_q.push_back(real'(knot(8 * (k + 1))));
        end
        run_stream("post", 0, 0, 0.0);

        // random sweep over (-16, 0]
        for (int k = 0; k < 200; k++) begin
            m = int'($urandom_range(0, (1 << 20) - 1));
            in_q.push_back(to_fp32(-real'(m) / 65536.0));
            ideal_q.push_back(interp_model(m));
        end
        run_stream("sweep", 0, 0, 2.0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
